// File: rtl/whack_pkg.sv
// Shared types and defaults for the Whack game blocks (scheduler, display, LFSR users).
package whack_pkg;

    typedef enum logic [1:0] {IDLE, GAP, UP, DONE} state_t;

    // Galois form of x^8 + x^6 + x^5 + x^4 + 1, shifting right
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int DEF_NUM_HOLES   = 8;
    localparam int DEF_ON_TICKS    = 3;
    localparam int DEF_GAP_TICKS   = 1;
    localparam int DEF_ROUND_TICKS = 60;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/whack_lfsr.sv
// Free-running 8-bit Galois LFSR; advances every clock, SEED restored on reset.
module whack_lfsr
    import whack_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) value <= SEED;
        else     value <= lfsr_step(value);
    end

endmodule

// File: rtl/mole_scheduler.sv
// Whack round sequencer: pops moles on pseudo-random holes, scores hits and
// runs the round countdown, all paced by the rate-divider tick.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int         NUM_HOLES   = DEF_NUM_HOLES,
    parameter int         ON_TICKS    = DEF_ON_TICKS,
    parameter int         GAP_TICKS   = DEF_GAP_TICKS,
    parameter int         ROUND_TICKS = DEF_ROUND_TICKS,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  logic                 ClockIn,
    input  logic                 Reset,
    input  logic                 Tick,
    input  logic                 Start,
    input  logic [NUM_HOLES-1:0] Hit,
    output logic [NUM_HOLES-1:0] MoleMask,
    output logic [7:0]           Score,
    output logic [7:0]           TimeLeft,
    output logic                 HitAck,
    output logic                 Active,
    output logic                 GameOver
);

    localparam int HW = $clog2(NUM_HOLES);

    state_t               state, state_nxt;
    logic [3:0]           gap_cnt, gap_nxt;
    logic [3:0]           up_cnt, up_nxt;
    logic [HW-1:0]        hole, hole_nxt;
    logic [HW-1:0]        cand, pick;
    logic [7:0]           lfsr;
    logic [7:0]           time_nxt, score_nxt;
    logic [NUM_HOLES-1:0] mask_nxt;
    logic                 ack_nxt;

    whack_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (ClockIn),
        .rst   (Reset),
        .value (lfsr)
    );

    // hole also serves as "previous hole"; stepping off it forbids repeats
    assign cand = HW'(lfsr % 8'(NUM_HOLES));
    assign pick = (cand == hole) ? cand + HW'(1) : cand;

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        up_nxt    = up_cnt;
        hole_nxt  = hole;
        time_nxt  = TimeLeft;
        score_nxt = Score;
        mask_nxt  = MoleMask;
        ack_nxt   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    state_nxt = GAP;
                    time_nxt  = 8'(ROUND_TICKS);
                    score_nxt = '0;
                    gap_nxt   = 4'(GAP_TICKS);
                    mask_nxt  = '0;
                end
            end
            GAP: begin
                if (Tick) begin
                    if (gap_cnt == 4'd1) begin
                        state_nxt = UP;
                        hole_nxt  = pick;
                        up_nxt    = 4'(ON_TICKS);
                        mask_nxt  = NUM_HOLES'(1) << pick;
                    end else begin
                        gap_nxt = gap_cnt - 4'd1;
                    end
                end
            end
            UP: begin
                if (Hit[hole]) begin
                    score_nxt = (Score == 8'hFF) ? Score : Score + 8'd1;
                    ack_nxt   = 1'b1;
                    mask_nxt  = '0;
                    state_nxt = GAP;
                    gap_nxt   = 4'(GAP_TICKS);
                end else if (Tick) begin
                    if (up_cnt == 4'd1) begin
                        mask_nxt  = '0;
                        state_nxt = GAP;
                        gap_nxt   = 4'(GAP_TICKS);
                    end else begin
                        up_nxt = up_cnt - 4'd1;
                    end
                end
            end
            default: ;
        endcase

        // Round expiry wins; a mole that never showed must not become the previous hole
        if (Tick && (state == GAP || state == UP)) begin
            if (TimeLeft == 8'd1) begin
                state_nxt = DONE;
                time_nxt  = '0;
                mask_nxt  = '0;
                hole_nxt  = hole;
            end else begin
                time_nxt = TimeLeft - 8'd1;
            end
        end
    end

    always_ff @(posedge ClockIn or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            up_cnt   <= '0;
            hole     <= '0;
            TimeLeft <= '0;
            Score    <= '0;
            MoleMask <= '0;
            HitAck   <= 1'b0;
            Active   <= 1'b0;
            GameOver <= 1'b0;
        end else begin
            state    <= state_nxt;
            gap_cnt  <= gap_nxt;
            up_cnt   <= up_nxt;
            hole     <= hole_nxt;
            TimeLeft <= time_nxt;
            Score    <= score_nxt;
            MoleMask <= mask_nxt;
            HitAck   <= ack_nxt;
            Active   <= (state_nxt == GAP) || (state_nxt == UP);
            GameOver <= (state_nxt == DONE);
        end
    end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
Sequences the mole pop-ups of one Whack round, using the one-cycle enable pulse from the rate divider as its time base. It picks a pseudo-random hole, holds the mole up for a fixed number of ticks, scores correct hits, and runs the round countdown. It sits between the rate divider and input debouncers on one side and the display/score logic on the other.

Parameters:
NUM_HOLES, 8, number of holes; power of 2, range 2..8; HW = $clog2(NUM_HOLES)
ON_TICKS, 3, ticks a mole stays up; range 1..15
GAP_TICKS, 1, ticks between moles; range 1..15
ROUND_TICKS, 60, round length in ticks; range 1..255
SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
ClockIn  input  1  system clock
Reset  input  1  asynchronous, active-high reset
Tick  input  1  one-cycle enable from the rate divider
Start  input  1  level or pulse; starts a round from IDLE or DONE
Hit  input  NUM_HOLES  debounced one-cycle hit pulses, one bit per hole
MoleMask  output  NUM_HOLES  one-hot raised mole, or all zeros
Score  output  8  correct hits this round; saturates at 255
TimeLeft  output  8  remaining round ticks
HitAck  output  1  one-cycle pulse when a hit is scored
Active  output  1  high in GAP or UP
GameOver  output  1  high in DONE

Behaviour:
- Reset (asynchronous): state IDLE, all outputs 0, internal counters 0, LFSR = SEED.
- All outputs are registered.
- States: IDLE, GAP, UP, DONE.
- IDLE or DONE with Start=1: next edge enters GAP.
  - TimeLeft = ROUND_TICKS, Score = 0, gap_cnt = GAP_TICKS, GameOver = 0.
  - Start in GAP or UP is ignored.
- GAP, on Tick:
  - If gap_cnt == 1: enter UP, latch hole from the LFSR, set MoleMask one-hot on the same edge, up_cnt = ON_TICKS.
  - Otherwise: gap_cnt decrements.
- UP, on Tick:
  - If up_cnt == 1: mole missed, MoleMask = 0, enter GAP, gap_cnt = GAP_TICKS.
  - Otherwise: up_cnt decrements.
- UP with Hit[hole] = 1 (with or without Tick):
  - Score increments (saturating), HitAck = 1 for one cycle.
  - MoleMask = 0, enter GAP, gap_cnt = GAP_TICKS.
  - A hit takes priority over up_cnt expiry in the same cycle.
- Hits on other holes, or any hit outside UP: ignored; no penalty.
- Round timer: on Tick in GAP or UP, TimeLeft decrements.
  - If TimeLeft == 1 on that Tick: enter DONE, TimeLeft = 0, MoleMask = 0, GameOver = 1.
  - A correct hit in that same cycle is still scored and HitAck still pulses.
  - Round expiry overrides every other next-state choice.
- DONE: Tick and Hit are ignored. Score and TimeLeft hold. GameOver holds until Start.
- Hole selection:
  - 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, advances every clock cycle.
  - candidate = lfsr[HW-1:0]. If candidate equals the previous hole, use candidate+1 mod NUM_HOLES.
  - So no two consecutive moles use the same hole. The previous hole is 0 after reset.
- Active = state is GAP or UP.
- Reset asserted mid-round: immediate return to the reset state; no partial score is kept.

Decomposition:
- Package whack_pkg holds:
  - state enum {IDLE, GAP, UP, DONE}
  - LFSR tap mask constant 8'hB8
  - default NUM_HOLES, ON_TICKS, GAP_TICKS and ROUND_TICKS constants, shared with the display block
- One sub-module: whack_lfsr, an 8-bit Galois LFSR with a SEED parameter, async reset and a free-running output. It is reused later for the bomb/decoy feature.

Test Plan:
1. Defaults; Start, then 1 Tick -> Active=1 and MoleMask one-hot. No hits and 3 more Ticks -> MoleMask=0, Score=0, TimeLeft=56.
2. Mole up on hole k; pulse Hit[k] with no Tick -> next edge Score=1, HitAck high for exactly 1 cycle, MoleMask=0. Hit[(k+1)%8] beforehand -> no change.
3. ROUND_TICKS=5 with 5 Ticks -> GameOver=1, TimeLeft=0, MoleMask=0. Further Ticks and Hits -> no change. Start -> Score=0, TimeLeft=5, GameOver=0.
4. Correct Hit in the same cycle as the final up_cnt Tick and the final round Tick -> Score increments, HitAck=1, state DONE.
5. Reset asserted mid-UP, between clock edges -> MoleMask, Score, TimeLeft, Active and HitAck go to 0 before the next edge. Start while Active -> no effect on TimeLeft or Score.
6. Run 200 moles with NUM_HOLES=4 -> no consecutive repeated hole, every hole used at least once, and MoleMask always one-hot or zero.
